pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 10 +
 rtl/sync_2ff.sv | 19 +
 rtl/pll_reset_sequencer.sv | 85 ++++++++
 tb/tb_pll_reset_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: FSM encoding, counter width and saturating helper
// shared by the PLL reset sequencer.
package pll_seq_pkg;
   localparam int CNT_W = 16;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef enum logic [1:0] {HOLD, WAIT_LOCK, STABLE, RUN} seq_state_t;
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous status bit.
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);
   logic meta_q, sync_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end
   assign q = sync_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, waits for a stable lock and then
// releases the downstream system reset, retrying on timeout or lock loss.
module pll_reset_sequencer #(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 65535,
   parameter int unsigned STABLE_CYCLES  = 1024
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       locked,
   input  logic       soft_reset_req,
   output logic       pll_rst,
   output logic       sys_reset_n,
   output logic       running,
   output logic [3:0] retry_count,
   output logic [3:0] lost_count
);
   import pll_seq_pkg::*;
   localparam cnt_t HOLD_LAST    = cnt_t'(PLL_RST_CYCLES - 1);
   localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
   localparam cnt_t STABLE_LAST  = cnt_t'(STABLE_CYCLES - 1);
   logic       locked_s;
   seq_state_t state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   logic [3:0] retry_count_q, retry_count_d, lost_count_q, lost_count_d;
   logic       pll_rst_q, sys_reset_n_q, running_q;
   sync_2ff u_lock_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (locked),
      .q       (locked_s)
   );
   always_comb begin
      state_d       = state_q;
      retry_count_d = retry_count_q;
      lost_count_d  = lost_count_q;
      if (soft_reset_req) state_d = HOLD;
      else begin
         case (state_q)
            HOLD:      if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
               if (locked_s) state_d = STABLE;
               else if (cnt_q == TIMEOUT_LAST) begin
                  state_d       = HOLD;
                  retry_count_d = sat_inc4(retry_count_q);
               end
            end
            STABLE:    state_d = !locked_s ? HOLD : (cnt_q == STABLE_LAST) ? RUN : STABLE;
            RUN: begin
               if (!locked_s) begin
                  state_d      = HOLD;
                  lost_count_d = sat_inc4(lost_count_q);
               end
            end
            default:   state_d = HOLD;
         endcase
      end
      // a soft request restarts the hold window even when already in HOLD
      cnt_d = (soft_reset_req || state_d != state_q) ? '0 : (&cnt_q) ? cnt_q : cnt_q + cnt_t'(1);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= HOLD;
         cnt_q         <= '0;
         retry_count_q <= '0;
         lost_count_q  <= '0;
         pll_rst_q     <= 1'b1;
         sys_reset_n_q <= 1'b0;
         running_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         retry_count_q <= retry_count_d;
         lost_count_q  <= lost_count_d;
         pll_rst_q     <= state_d == HOLD;
         sys_reset_n_q <= state_d == RUN;
         running_q     <= state_d == RUN;
      end
   end
   assign pll_rst     = pll_rst_q;
   assign sys_reset_n = sys_reset_n_q;
   assign running     = running_q;
   assign retry_count = retry_count_q;
   assign lost_count  = lost_count_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed scenarios checked against a time-based
// behavioural model every cycle, plus hand-computed literal expectations.
module tb_pll_reset_sequencer;
   localparam int PRC = 8, LTO = 100, STC = 16;
   localparam int MH = 0, MW = 1, MS = 2, MR = 3;
   logic       clk = 1'b0, reset_n = 1'b0, locked = 1'b0, soft_reset_req = 1'b0;
   logic       pll_rst, sys_reset_n, running;
   logic [3:0] retry_count, lost_count;
   int         vec = 0, err = 0;
   int         m_state = MH, m_entry = 0, cyc = 0, m_retry = 0, m_lost = 0;
   bit         s1 = 1'b0, s2 = 1'b0;
   pll_reset_sequencer #(.PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO), .STABLE_CYCLES(STC)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .locked         (locked),
      .soft_reset_req (soft_reset_req),
      .pll_rst        (pll_rst),
      .sys_reset_n    (sys_reset_n),
      .running        (running),
      .retry_count    (retry_count),
      .lost_count     (lost_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // Model: each phase is judged by how many edges have elapsed since it was entered.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_state = MH; m_entry = 0; cyc = 0; m_retry = 0; m_lost = 0; s1 = 0; s2 = 0;
      end else begin
         int nxt, el;
         bit ls;
         ls = s2; s2 = s1; s1 = locked;
         cyc++;
         el = cyc - m_entry;
         nxt = m_state;
         if (soft_reset_req) nxt = MH;
         else if (m_state == MH) begin
            if (el >= PRC) nxt = MW;
         end else if (m_state == MW) begin
            if (ls) nxt = MS;
            else if (el >= LTO) begin nxt = MH; m_retry = (m_retry < 15) ? m_retry + 1 : 15; end
         end else if (m_state == MS) begin
            if (!ls) nxt = MH;
            else if (el >= STC) nxt = MR;
         end else if (!ls) begin
            nxt = MH; m_lost = (m_lost < 15) ? m_lost + 1 : 15;
         end
         if (soft_reset_req || nxt != m_state) m_entry = cyc;
         m_state = nxt;
      end
   end
   always @(negedge clk) begin
      chk("pll_rst", pll_rst, m_state == MH);
      chk("sys_reset_n", sys_reset_n, m_state == MR);
      chk("running", running, m_state == MR);
      chk("retry_count", retry_count, m_retry);
      chk("lost_count", lost_count, m_lost);
   end
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic wait_sys(input logic lvl, input int lim, output int n, output logic saw_pll);
      n = 0; saw_pll = 1'b0;
      for (int i = 1; i <= lim; i++) begin
         @(negedge clk);
         saw_pll |= pll_rst;
         if (sys_reset_n === lvl) begin n = i; break; end
      end
   endtask
   task automatic chk_reset(input string nm);
      chk({nm, "_pll_rst"}, pll_rst, 1);
      chk({nm, "_sys_reset_n"}, sys_reset_n, 0);
      chk({nm, "_running"}, running, 0);
      chk({nm, "_retry"}, retry_count, 0);
      chk({nm, "_lost"}, lost_count, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n, hi;
      logic sp;
      #12 chk_reset("por");
      @(negedge clk) reset_n = 1'b1;
      wait_n(100);
      hi = 0;
      for (int k = 101; k <= 130; k++) begin
         @(negedge clk);
         hi += int'(pll_rst);
         if (k == 107) chk("A_retry_107", retry_count, 0);
         if (k == 108) chk("A_retry_108", retry_count, 1);
      end
      chk("A_pulse_width", hi, 8);
      wait_n(86);
      chk("A_retry_216", retry_count, 2);
      wait_n(1944);
      chk("A_retry_sat", retry_count, 15);
      chk("A_sys_low", sys_reset_n, 0);
      #2 reset_n = 1'b0;
      #1 chk_reset("B_async");
      @(negedge clk) reset_n = 1'b1;
      wait_n(105);
      locked = 1'b1;
      wait_n(3);
      chk("B_tie_retry", retry_count, 0);
      chk("B_tie_pll", pll_rst, 0);
      wait_n(15);
      chk("B_sys_123", sys_reset_n, 0);
      wait_n(1);
      chk("B_sys_124", sys_reset_n, 1);
      chk("B_run_124", running, 1);
      #2 begin reset_n = 1'b0; locked = 1'b0; end
      #1 chk_reset("C_async");
      @(negedge clk) reset_n = 1'b1;
      wait_n(7);
      chk("C_pll_7", pll_rst, 1);
      wait_n(1);
      chk("C_pll_8", pll_rst, 0);
      wait_n(12);
      locked = 1'b1;
      wait_sys(1'b1, 60, n, sp);
      chk("C_release_edge", n, 19);
      chk("C_running", running, 1);
      wait_n(5);
      locked = 1'b0;
      wait_sys(1'b0, 20, n, sp);
      chk("D_fall_edge", n, 3);
      chk("D_lost", lost_count, 1);
      wait_n(2);
      locked = 1'b1;
      wait_sys(1'b1, 100, n, sp);
      chk("D_relock_found", n != 0, 1);
      chk("D_retry", retry_count, 0);
      wait_n(5);
      soft_reset_req = 1'b1;
      @(negedge clk) soft_reset_req = 1'b0;
      chk("E_pll", pll_rst, 1);
      chk("E_sys", sys_reset_n, 0);
      chk("E_run", running, 0);
      chk("E_retry", retry_count, 0);
      chk("E_lost", lost_count, 1);
      wait_n(17);
      locked = 1'b0;
      wait_n(3);
      locked = 1'b1;
      wait_n(5);
      chk("F_sys_held", sys_reset_n, 0);
      chk("F_back_in_hold", pll_rst, 1);
      wait_sys(1'b1, 100, n, sp);
      chk("F_reseq_found", n != 0, 1);
      chk("F_retry", retry_count, 0);
      chk("F_lost", lost_count, 1);
      wait_n(3);
      #2 reset_n = 1'b0;
      #1 chk_reset("G_async");
      wait_n(2);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
